rgb_level_sequencer: RTL and testbench
======================================

# rgb_level_sequencer

Owns the three 8-bit colour levels (red, green, blue) that drive the per-channel PWM generators. It serialises brightness up/down requests from the three channels onto one shared external 8-bit add/subtract ALU. Each result is saturated to 0..255 and written back to the owning channel's level register. Sits between the user-input/debounce logic and the PWM generators.

## Interface
- STEP, default 8'd10: magnitude added or subtracted per granted request.
- RESET_LEVEL, default 8'd100: value loaded into every level register on reset.

Ports:
- clk  in  1: system clock, all state on rising edge.
- rst_n  in  1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- up_req  in  3: per-channel increment request, level-sensitive. Bit 0 = red, 1 = green, 2 = blue.
- dn_req  in  3: per-channel decrement request, level-sensitive, same bit order.
- ack  out  3: one-cycle grant-complete pulse for the served channel.
- busy  out  1: high while a transaction is in CALC or DONE.
- alu_a  out  8: ALU operand A, registered.
- alu_b  out  8: ALU operand B, registered.
- alu_sub  out  1: ALU mode, 0 = add, 1 = subtract, registered.
- alu_out  in  8: combinational ALU result.
- alu_carry  in  1: ALU carry.
  - In add mode, 1 means the sum exceeded 255.
  - In subtract mode, 1 means no borrow (A >= B).
- red  out  8: red level to PWM, registered.
- green  out  8: green level to PWM, registered.
- blue  out  8: blue level to PWM, registered.

## Operation
- Reset values:
  - red/green/blue = RESET_LEVEL.
  - ack = 0, busy = 0, alu_a = 0, alu_b = 0, alu_sub = 0.
  - State = IDLE.
  - Round-robin pointer last = 2 (blue), so red has first priority.
- Channel i is pending when up_req[i] | dn_req[i].
- **IDLE:**
  - Grant the first pending channel in order last+1, last+2, last+3 (mod 3). Set last <= granted channel, sel <= channel.
  - Load alu_a <= level[sel], alu_b <= STEP.
  - up only: alu_sub <= 0. dn only: alu_sub <= 1.
  - up and dn both high on the same channel: set a no-op flag; alu_sub <= 0.
  - Go to CALC. With nothing pending, stay in IDLE with all outputs held.
- **CALC:**
  - Sample alu_out/alu_carry at the closing edge. The write value is:
    - add with carry = 1: 8'd255.
    - subtract with carry = 0: 8'd0.
    - otherwise: alu_out.
  - Write level[sel] unless no-op. Set ack[sel] <= 1. Go to DONE.
- **DONE:** ack[sel] high for exactly this cycle; next edge clears ack and returns to IDLE.
- busy = (state == CALC) | (state == DONE), registered.
- Handshake:
  - The requester holds its req until it sees ack, then deasserts it on that same edge.
  - A req still high when IDLE is re-entered counts as a new request and consumes another step.
  - Requests arriving during CALC/DONE are not lost; they are arbitrated in the next IDLE.
- Level registers change only at the end of CALC, or on reset.

## Timing
- Request sampled at IDLE edge t0. alu_a/alu_b/alu_sub are valid during cycle t0+1 (CALC).
- Level update and ack are both visible in cycle t0+2 (DONE). IDLE is back in cycle t0+3.
- Throughput: one transaction per 3 cycles. Three continuously pending channels are each served once per 9 cycles, in strict rotation.
- Saturation boundaries:
  - 250 + 10 gives 255.
  - 5 - 10 gives 0.
  - 10 - 10 gives 0 (carry = 1, no clamp needed).
  - 255 + 10 stays at 255.
  - 0 - 10 stays at 0.
- rst_n low at any time, including mid-CALC or DONE:
  - Immediately force all reset values and abort the transaction.
  - No write, no ack; the pending requester is not acknowledged.
- The ALU is treated as purely combinational and must settle within one clk period.

## Test plan
- Reset: hold rst_n low 3 cycles, release. Required: red = green = blue = 100, ack = 0, busy = 0, alu_sub = 0 during and after reset.
- Single increment: up_req = 3'b001 at edge t0. Required:
  - alu_a = 100, alu_b = 10, alu_sub = 0 in t0+1.
  - red = 110 and ack = 3'b001 in t0+2.
  - busy low in t0+3.
- Saturation: drive green to 250, then one up. Required: green = 255. Drive blue to 5, then one dn. Required: blue = 0. A further dn leaves blue at 0 with ack still pulsed.
- Arbitration: up_req = 3'b111 held continuously from reset release. Required:
  - acks in order 001, 010, 100, 001, spaced 3 cycles apart.
  - Each level increments by 10 per ack.
- Conflict: up_req[0] = dn_req[0] = 1 together. Required: ack[0] pulses at t0+2, red unchanged at 100.
- Reset mid-operation: dn_req = 3'b010, assert rst_n low during CALC. Required: green = 100, ack never pulses, state IDLE after release.

Source files
------------

// File: rtl/rgb_level_sequencer.sv
// RGB level sequencer: round-robin arbitration of per-channel up/down
// brightness requests onto one shared external add/subtract ALU, with
// saturated write-back into the three 8-bit level registers.
module rgb_level_sequencer #(
   parameter logic [7:0] STEP        = 8'd10,
   parameter logic [7:0] RESET_LEVEL = 8'd100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] up_req,
   input  logic [2:0] dn_req,
   output logic [2:0] ack,
   output logic       busy,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic       alu_sub,
   input  logic [7:0] alu_out,
   input  logic       alu_carry,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t      state;
   logic [1:0]  last;
   logic [1:0]  sel;
   logic        noop;
   logic [7:0]  level [3];
   logic [2:0]  pend;
   logic [1:0]  grant;
   logic        grant_vld;
   logic [7:0]  wr_val;

   assign pend  = up_req | dn_req;
   assign red   = level[0];
   assign green = level[1];
   assign blue  = level[2];

   // Round-robin pick: first pending channel after the last one served.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      for (int unsigned k = 1; k <= 3; k++) begin
         int unsigned idx;
         idx = (32'(last) + k) % 3;
         if (!grant_vld && pend[idx]) begin
            grant_vld = 1'b1;
            grant     = idx[1:0];
         end
      end
   end

   // Saturate the ALU result using its carry/borrow flag.
   always_comb begin
      wr_val = alu_out;
      if (!alu_sub && alu_carry)
         wr_val = '1;
      else if (alu_sub && !alu_carry)
         wr_val = '0;
   end

   // Transaction FSM with registered ALU operands, levels, ack and busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last    <= 2'd2;
         sel     <= '0;
         noop    <= 1'b0;
         ack     <= '0;
         busy    <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sub <= 1'b0;
         for (int unsigned i = 0; i < 3; i++)
            level[i] <= RESET_LEVEL;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  last    <= grant;
                  sel     <= grant;
                  alu_a   <= level[grant];
                  alu_b   <= STEP;
                  noop    <= up_req[grant] & dn_req[grant];
                  alu_sub <= dn_req[grant] & ~up_req[grant];
                  busy    <= 1'b1;
                  state   <= CALC;
               end
            end
            CALC: begin
               if (!noop)
                  level[sel] <= wr_val;
               ack   <= 3'b001 << sel;
               state <= DONE;
            end
            DONE: begin
               ack   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_level_sequencer.sv
// Directed self-checking bench for rgb_level_sequencer with a behavioural
// model of the external add/subtract ALU.
module tb_rgb_level_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] up_req = '0;
   logic [2:0] dn_req = '0;
   logic [2:0] ack;
   logic       busy;
   logic [7:0] alu_a, alu_b;
   logic       alu_sub;
   logic [7:0] alu_out;
   logic       alu_carry;
   logic [7:0] red, green, blue;

   int errors = 0;
   int checks = 0;

   rgb_level_sequencer #(.STEP(8'd10), .RESET_LEVEL(8'd100)) dut (
      .clk(clk), .rst_n(rst_n), .up_req(up_req), .dn_req(dn_req),
      .ack(ack), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
      .alu_sub(alu_sub), .alu_out(alu_out), .alu_carry(alu_carry),
      .red(red), .green(green), .blue(blue)
   );

   always #5 clk = ~clk;

   // External ALU: add gives carry on overflow, subtract gives carry when A >= B.
   logic [8:0] sum;
   always_comb begin
      sum       = {1'b0, alu_a} + {1'b0, alu_b};
      alu_out   = alu_sub ? (alu_a - alu_b) : sum[7:0];
      alu_carry = alu_sub ? (alu_a >= alu_b) : sum[8];
   end

   // Called at a negedge while idle; returns the first nonzero ack (or 0 on timeout).
   task automatic transact(input logic [2:0] up, input logic [2:0] dn, output logic [2:0] got);
      got    = '0;
      up_req = up;
      dn_req = dn;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack !== 3'b000) begin
            got = ack;
            break;
         end
      end
      up_req = '0;
      dn_req = '0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      up_req = '0;
      dn_req = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      up_req = '0;
      dn_req = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 3) rst_n = 1'b1;
         checks++;
         if ({red, green, blue} !== {8'd100, 8'd100, 8'd100}) begin
            errors++;
            $display("FAIL reset_levels: got %0d/%0d/%0d expected 100/100/100", red, green, blue);
         end
         checks++;
         if ({ack, busy, alu_sub, alu_a, alu_b} !== 21'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b busy=%b sub=%b a=%0d b=%0d expected all 0",
                     ack, busy, alu_sub, alu_a, alu_b);
         end
      end
   endtask

   task automatic test_single_inc();
      do_reset();
      up_req = 3'b001;
      @(negedge clk);
      checks++;
      if ({alu_a, alu_b, alu_sub, busy} !== {8'd100, 8'd10, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL inc_operands: a=%0d b=%0d sub=%b busy=%b expected a=100 b=10 sub=0 busy=1",
                  alu_a, alu_b, alu_sub, busy);
      end
      @(negedge clk);
      checks++;
      if (red !== 8'd110 || ack !== 3'b001) begin
         errors++;
         $display("FAIL inc_result: red=%0d ack=%b expected red=110 ack=001", red, ack);
      end
      up_req = '0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ack !== 3'b000) begin
         errors++;
         $display("FAIL inc_idle: busy=%b ack=%b expected busy=0 ack=000", busy, ack);
      end
   endtask

   task automatic test_saturation();
      logic [2:0] got;
      do_reset();
      for (int n = 0; n < 15; n++) begin
         transact(3'b010, 3'b000, got);
         checks++;
         if (got !== 3'b010) begin
            errors++;
            $display("FAIL sat_green_up_ack: got %b expected 010", got);
         end
      end
      checks++;
      if (green !== 8'd250) begin
         errors++;
         $display("FAIL sat_green_250: got %0d expected 250", green);
      end
      transact(3'b010, 3'b000, got);
      checks++;
      if (green !== 8'd255 || got !== 3'b010) begin
         errors++;
         $display("FAIL sat_250_plus: green=%0d ack=%b expected 255 010", green, got);
      end
      transact(3'b010, 3'b000, got);
      checks++;
      if (green !== 8'd255 || got !== 3'b010) begin
         errors++;
         $display("FAIL sat_255_plus: green=%0d ack=%b expected 255 010", green, got);
      end
      for (int n = 0; n < 10; n++) transact(3'b000, 3'b100, got);
      checks++;
      if (blue !== 8'd0) begin
         errors++;
         $display("FAIL sat_10_minus: blue=%0d expected 0", blue);
      end
      transact(3'b000, 3'b100, got);
      checks++;
      if (blue !== 8'd0 || got !== 3'b100) begin
         errors++;
         $display("FAIL sat_0_minus: blue=%0d ack=%b expected 0 100", blue, got);
      end
      for (int n = 0; n < 25; n++) transact(3'b000, 3'b010, got);
      checks++;
      if (green !== 8'd5) begin
         errors++;
         $display("FAIL sat_green_5: got %0d expected 5", green);
      end
      transact(3'b000, 3'b010, got);
      checks++;
      if (green !== 8'd0 || got !== 3'b010) begin
         errors++;
         $display("FAIL sat_5_minus: green=%0d ack=%b expected 0 010", green, got);
      end
      checks++;
      if (red !== 8'd100) begin
         errors++;
         $display("FAIL sat_red_untouched: got %0d expected 100", red);
      end
   endtask

   task automatic test_arbitration();
      logic [7:0] exp_lvl [3];
      logic [2:0] exp_ack;
      for (int i = 0; i < 3; i++) exp_lvl[i] = 8'd100;
      rst_n  = 1'b0;
      up_req = '0;
      dn_req = '0;
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      up_req = 3'b111;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         exp_ack = 3'b000;
         if (c % 3 == 2) begin
            exp_ack = 3'b001 << ((c - 2) / 3 % 3);
            exp_lvl[(c - 2) / 3 % 3] = exp_lvl[(c - 2) / 3 % 3] + 8'd10;
         end
         checks++;
         if (ack !== exp_ack) begin
            errors++;
            $display("FAIL arb_ack cycle %0d: got %b expected %b", c, ack, exp_ack);
         end
         if (exp_ack != 3'b000) begin
            checks++;
            if ({red, green, blue} !== {exp_lvl[0], exp_lvl[1], exp_lvl[2]}) begin
               errors++;
               $display("FAIL arb_levels cycle %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                        c, red, green, blue, exp_lvl[0], exp_lvl[1], exp_lvl[2]);
            end
         end
      end
      up_req = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_conflict();
      do_reset();
      up_req = 3'b001;
      dn_req = 3'b001;
      @(negedge clk);
      checks++;
      if (alu_sub !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL conflict_calc: sub=%b busy=%b expected sub=0 busy=1", alu_sub, busy);
      end
      @(negedge clk);
      checks++;
      if (ack !== 3'b001 || red !== 8'd100) begin
         errors++;
         $display("FAIL conflict_noop: ack=%b red=%0d expected ack=001 red=100", ack, red);
      end
      up_req = '0;
      dn_req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      logic [2:0] got;
      logic       seen_ack;
      do_reset();
      dn_req = 3'b010;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || alu_sub !== 1'b1) begin
         errors++;
         $display("FAIL midrst_calc: busy=%b sub=%b expected 1 1", busy, alu_sub);
      end
      rst_n  = 1'b0;
      dn_req = '0;
      #1;
      checks++;
      if ({busy, ack, alu_a, alu_sub} !== 13'd0 || green !== 8'd100) begin
         errors++;
         $display("FAIL midrst_async: busy=%b ack=%b a=%0d sub=%b green=%0d expected 0 000 0 0 100",
                  busy, ack, alu_a, alu_sub, green);
      end
      seen_ack = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ack !== 3'b000) seen_ack = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (ack !== 3'b000 || busy !== 1'b0) seen_ack = 1'b1;
      end
      checks++;
      if (seen_ack !== 1'b0 || green !== 8'd100) begin
         errors++;
         $display("FAIL midrst_after: stray_activity=%b green=%0d expected 0 100", seen_ack, green);
      end
      transact(3'b010, 3'b000, got);
      checks++;
      if (got !== 3'b010 || green !== 8'd110) begin
         errors++;
         $display("FAIL midrst_resume: ack=%b green=%0d expected 010 110", got, green);
      end
   endtask

   initial begin
      test_reset();
      test_single_inc();
      test_saturation();
      test_arbitration();
      test_conflict();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
